// File: rtl/mem_arbiter_pkg.sv
// Shared widths, requester identifiers and per-requester response state for mem_arbiter.
package mem_arbiter_pkg;

  localparam int unsigned MEMSIZE = 8;
  localparam int unsigned DWIDTH  = 8;
  localparam int unsigned NREQ    = 2;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  typedef struct packed {
    logic              rd_pend;
    logic              rsp_valid;
    logic [DWIDTH-1:0] rsp_rdata;
  } rsp_state_t;

  // Writes always pass; a read waits until the previous read has been captured and consumed.
  function automatic logic is_elig(input logic valid, input logic we,
                                   input logic pend, input logic held);
    return valid && (we || (!pend && !held));
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester's request and read-response channels.
interface mem_arbiter_if import mem_arbiter_pkg::*; ();

  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [MEMSIZE-1:0] req_addr;
  logic [DWIDTH-1:0]  req_wdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DWIDTH-1:0]  rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin grant; ties go to the requester that did not win last.
module arb_rr2 import mem_arbiter_pkg::*; (
  input  logic       clk,
  input  logic       xrst,
  input  logic [1:0] elig,
  output logic [1:0] grant
);

  req_id_e last_q, last_d;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) last_q <= REQ1;
    else       last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (grant[0])      last_d = REQ0;
    else if (grant[1]) last_d = REQ1;
  end

  always_comb begin
    grant = '0;
    unique case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_q == REQ1) ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between two requesters; captures read data into
// per-requester response registers one cycle after the granted read address.
module mem_arbiter import mem_arbiter_pkg::*; (
  input  logic               clk,
  input  logic               xrst,
  mem_arbiter_if.slave       req_0,
  mem_arbiter_if.slave       req_1,
  output logic               mem_we,
  output logic [MEMSIZE-1:0] mem_addr,
  output logic [DWIDTH-1:0]  mem_wdata,
  input  logic [DWIDTH-1:0]  mem_rdata
);

  logic [NREQ-1:0]    valid_w, we_w, rsp_ready_w, elig, grant;
  logic [NREQ-1:0]    pend_w, held_w;
  logic [MEMSIZE-1:0] addr_w  [NREQ];
  logic [DWIDTH-1:0]  wdata_w [NREQ];
  logic [DWIDTH-1:0]  rdata_w [NREQ];

  assign valid_w     = {req_1.req_valid, req_0.req_valid};
  assign we_w        = {req_1.req_we,    req_0.req_we};
  assign rsp_ready_w = {req_1.rsp_ready, req_0.rsp_ready};
  assign addr_w[0]   = req_0.req_addr;
  assign addr_w[1]   = req_1.req_addr;
  assign wdata_w[0]  = req_0.req_wdata;
  assign wdata_w[1]  = req_1.req_wdata;

  assign req_0.req_ready = grant[0];
  assign req_1.req_ready = grant[1];
  assign req_0.rsp_valid = held_w[0];
  assign req_1.rsp_valid = held_w[1];
  assign req_0.rsp_rdata = rdata_w[0];
  assign req_1.rsp_rdata = rdata_w[1];

  arb_rr2 u_arb (
    .clk   (clk),
    .xrst  (xrst),
    .elig  (elig),
    .grant (grant)
  );

  for (genvar g = 0; g < NREQ; g++) begin : g_rsp
    rsp_state_t st_q, st_d;

    // Gating with xrst keeps req_ready low for the whole reset assertion.
    assign elig[g]    = xrst && is_elig(valid_w[g], we_w[g], st_q.rd_pend, st_q.rsp_valid);
    assign pend_w[g]  = st_q.rd_pend;
    assign held_w[g]  = st_q.rsp_valid;
    assign rdata_w[g] = st_q.rsp_rdata;

    always_comb begin
      st_d = st_q;
      if (st_q.rd_pend) begin
        st_d.rd_pend   = 1'b0;
        st_d.rsp_valid = 1'b1;
        st_d.rsp_rdata = mem_rdata;
      end else if (st_q.rsp_valid && rsp_ready_w[g]) begin
        st_d.rsp_valid = 1'b0;
      end
      if (grant[g] && !we_w[g]) st_d.rd_pend = 1'b1;
    end

    always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) st_q <= '0;
      else       st_q <= st_d;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        mem_we    = we_w[i];
        mem_addr  = addr_w[i];
        mem_wdata = wdata_w[i];
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester round-robin arbiter that shares the single-port `memory` block (synchronous write, registered read address) between two masters. Each requester gets a valid/ready request channel and a valid/ready read-response channel. The block owns the memory's `mem_we`/`mem_addr`/`mem_wdata` inputs and captures `mem_rdata` into per-requester response registers. It sits between the bus-side adapters and `memory`.

## Interface
Parameters:
- `MEMSIZE`, from `parameters.vh`: address width; must match `memory`.
- `DWIDTH`, from `parameters.vh`: data width; must match `memory`.

Ports (i = 0, 1; one full set per requester):
- `clk` in 1: single clock; all state on rising edge.
- `xrst` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: request present.
- `req_ready_i` out 1: request accepted this cycle (combinational).
- `req_we_i` in 1: 1 = write, 0 = read.
- `req_addr_i` in MEMSIZE: word address.
- `req_wdata_i` in DWIDTH: write data.
- `rsp_valid_i` out 1: read data held for requester i.
- `rsp_ready_i` in 1: requester consumes the response.
- `rsp_rdata_i` out DWIDTH: read data.
- `mem_we` out 1: to `memory`.
- `mem_addr` out MEMSIZE: to `memory`.
- `mem_wdata` out DWIDTH: to `memory`.
- `mem_rdata` in DWIDTH: from `memory`; valid the cycle after its address is presented.

## Operation
- Eligibility:
  - `elig_i = req_valid_i && (req_we_i || (!rd_pend_i && !rsp_valid_i))`.
  - Writes are always eligible.
  - A requester has at most one read in flight or held.
- Grant:
  - If only one requester is eligible, grant it.
  - If both are eligible, grant the one not equal to `last_grant`.
  - `last_grant` updates only on a grant; reset value 1, so requester 0 wins the first tie.
- `req_ready_i = grant_i`. A handshake occurs when `req_valid_i && req_ready_i`.
- Memory drive:
  - With a grant: `mem_addr`/`mem_wdata` = the granted requester's fields; `mem_we` = granted `req_we`.
  - With no grant: all three = 0.
- Granted read: `rd_pend_i` is set at the end of the grant cycle.
- Capture: in the next cycle, `mem_rdata` is loaded into `rsp_rdata_i`; `rsp_valid_i` is set and `rd_pend_i` is cleared at that edge.
- Response: `rsp_valid_i` clears on `rsp_valid_i && rsp_ready_i`. `rsp_rdata_i` holds its value until the next capture.
- Writes produce no response. A write completes at the handshake edge.
- Other requester unaffected: a requester may issue writes while its own read is pending or held; the other requester's pending read is not disturbed.
- Simultaneous events:
  - Both requesters valid with writes to the same address: only one is granted per cycle, so there is no conflict.
  - A read of an address written the previous cycle returns the new data.

## Timing
- Read latency: grant in cycle N; `rsp_valid_i` high from cycle N+2.
- Per-requester read rate: at most one read per 3 cycles when the response is consumed immediately.
- Aggregate throughput: one memory access per cycle.
- Write: memory is updated at the end of the grant cycle.
- Reset values: `rd_pend_*` = 0, `rsp_valid_*` = 0, `rsp_rdata_*` = 0, `last_grant` = 1.
  - Combinational outputs are 0 when no request is valid.
  - `req_ready_*` = 0 while `xrst` is low, since eligibility is gated by reset.
- Reset mid-read: pending reads and held responses are discarded and no response is issued. Memory contents are unaffected.

## Structure
- `MEMSIZE` and `DWIDTH` stay in `parameters.vh`, included by both `mem_arbiter` and `memory`.
- The round-robin state and grant logic live in sub-module `arb_rr2`:
  - Inputs: `elig[1:0]`.
  - Outputs: one-hot `grant[1:0]`.
  - Contains the `last_grant` register, with the same `clk`/`xrst`.
- Per-requester response tracking (`rd_pend`, `rsp_valid`, `rsp_rdata`) is instantiated twice via a generate loop inside `mem_arbiter`.

## Test plan
- Single write/read:
  - Requester 0 writes 0xA5 to address 3, then reads address 3.
  - Required: `rsp_valid_0` rises 2 cycles after the read grant with `rsp_rdata_0` = 0xA5.
  - Required: `rsp_valid_1` stays 0 throughout.
- Round-robin:
  - Both requesters hold write requests for 6 cycles.
  - Required: grants alternate 0,1,0,1,0,1, starting with 0 after reset.
- Response backpressure:
  - Requester 1 reads, then holds `rsp_ready_1` = 0 for 5 cycles while keeping `req_valid_1` high with a read.
  - Required: `req_ready_1` stays 0 and `rsp_rdata_1` is stable.
  - Required: the next read is granted in the cycle after `rsp_ready_1` is asserted.
- Write during pending read:
  - Requester 0 has a read pending or held and issues a write.
  - Required: the write is granted, and the held data is unchanged.
- Read-after-write across requesters:
  - Requester 0 writes 0x3C to address 7 in cycle N; requester 1 reads address 7 in cycle N+1.
  - Required: `rsp_rdata_1` = 0x3C.
- Reset mid-operation:
  - Assert `xrst` = 0 asynchronously one cycle after a read grant.
  - Required: `rsp_valid_*` = 0 immediately, no response after release, and `last_grant` = 1.
